// File: rtl/axis_sc16_if.sv
// AXI-Stream bundle for sc16 items: tdata[31:16] = I, tdata[15:0] = Q.
interface axis_sc16_if;
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_sc16_peak_meter.sv
// Pass-through AXI-Stream sc16 peak meter.
// Forwards items through a single output register and tracks per-window peak |I| and |Q|
// over 2^WIN_LOG2 accepted samples. Optional full-scale sample counter is enabled by
// defining AXIS_SC16_PEAK_METER_CLIP_COUNT_EN; otherwise clip_count is tied to zero.
module axis_sc16_peak_meter #(
    parameter int unsigned WIN_LOG2 = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    axis_sc16_if.slave        s_axis,
    axis_sc16_if.master       m_axis,
    input  logic              clear,
    output logic [15:0]       peak_i,
    output logic [15:0]       peak_q,
    output logic              peak_valid,
    output logic [CNT_W-1:0]  clip_count
);

    // |x| for 16-bit two's complement; the most negative value saturates to 32767
    function automatic logic [15:0] mag16(input logic [15:0] x);
        logic [15:0] r;
        if (x == 16'h8000) begin
            r = 16'h7FFF;
        end else if (x[15]) begin
            r = (~x) + 16'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

    function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
        return (a >= b) ? a : b;
    endfunction

    // ------------------------------------------------------------------
    // Ready bring-up: two flops so s_axis.tready first rises on the 2nd edge after release
    // ------------------------------------------------------------------
    logic arm_q, arm_d;
    logic rdy_q, rdy_d;

    // Next-state for the ready bring-up chain
    always_comb begin
        arm_d = 1'b1;
        rdy_d = arm_q;
    end

    // Ready bring-up registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            arm_q <= arm_d;
            rdy_q <= rdy_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding register stage
    // ------------------------------------------------------------------
    logic [31:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic        valid_q, valid_d;
    logic        s_ready;
    logic        s_hs;

    assign s_ready       = rdy_q & (~valid_q | m_axis.tready);
    assign s_hs          = s_axis.tvalid & s_ready;
    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tvalid = valid_q;

    // Load a new item on input handshake; drop valid once the held item is taken
    always_comb begin
        tdata_d = tdata_q;
        tlast_d = tlast_q;
        valid_d = valid_q;
        if (s_hs) begin
            tdata_d = s_axis.tdata;
            tlast_d = s_axis.tlast;
            valid_d = 1'b1;
        end else if (m_axis.tready) begin
            valid_d = 1'b0;
        end
    end

    // Output register; reset drops any in-flight item
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_q <= '0;
            tlast_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Window peak metering
    // ------------------------------------------------------------------
    logic [15:0]         mag_i, mag_q;
    logic [15:0]         acc_i_q, acc_i_d;
    logic [15:0]         acc_q_q, acc_q_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [15:0]         peak_i_q, peak_i_d;
    logic [15:0]         peak_q_q, peak_q_d;
    logic                peak_valid_q, peak_valid_d;
    logic                win_last;

    assign mag_i    = mag16(s_axis.tdata[31:16]);
    assign mag_q    = mag16(s_axis.tdata[15:0]);
    assign win_last = (cnt_q == {WIN_LOG2{1'b1}});

    // Accumulate max magnitudes; clear wins over a coinciding handshake
    always_comb begin
        acc_i_d      = acc_i_q;
        acc_q_d      = acc_q_q;
        cnt_d        = cnt_q;
        peak_i_d     = peak_i_q;
        peak_q_d     = peak_q_q;
        peak_valid_d = 1'b0;
        if (clear) begin
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
        end else if (s_hs) begin
            if (win_last) begin
                peak_i_d     = max16(acc_i_q, mag_i);
                peak_q_d     = max16(acc_q_q, mag_q);
                peak_valid_d = 1'b1;
                acc_i_d      = '0;
                acc_q_d      = '0;
                cnt_d        = '0;
            end else begin
                acc_i_d = max16(acc_i_q, mag_i);
                acc_q_d = max16(acc_q_q, mag_q);
                cnt_d   = cnt_q + WIN_LOG2'(1);
            end
        end
    end

    // Metering state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            cnt_q        <= '0;
            peak_i_q     <= '0;
            peak_q_q     <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            acc_i_q      <= acc_i_d;
            acc_q_q      <= acc_q_d;
            cnt_q        <= cnt_d;
            peak_i_q     <= peak_i_d;
            peak_q_q     <= peak_q_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign peak_i     = peak_i_q;
    assign peak_q     = peak_q_q;
    assign peak_valid = peak_valid_q;

    // ------------------------------------------------------------------
    // Optional full-scale sample counter
    // ------------------------------------------------------------------
`ifdef AXIS_SC16_PEAK_METER_CLIP_COUNT_EN
    logic [CNT_W-1:0] clip_q, clip_d;
    logic             clipped;

    // Either rail at a full-scale code marks the sample as clipped by the gain stage
    assign clipped = (s_axis.tdata[31:16] == 16'h7FFF) || (s_axis.tdata[31:16] == 16'h8000) ||
                     (s_axis.tdata[15:0]  == 16'h7FFF) || (s_axis.tdata[15:0]  == 16'h8000);

    // Saturating count of clipped handshakes; clear has priority
    always_comb begin
        clip_d = clip_q;
        if (clear) begin
            clip_d = '0;
        end else if (s_hs && clipped && (clip_q != {CNT_W{1'b1}})) begin
            clip_d = clip_q + CNT_W'(1);
        end
    end

    // Clip counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_q <= '0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clip_count = clip_q;
`else
    assign clip_count = '0;
`endif

endmodule

// File: tb/tb_axis_sc16_peak_meter.sv
// Self-checking bench for axis_sc16_peak_meter (WIN_LOG2 = 4) against a queue-based model.
module tb_axis_sc16_peak_meter;

    localparam int unsigned WinLog2 = 4;
    localparam int          Win     = 1 << WinLog2;
`ifdef AXIS_SC16_PEAK_METER_CLIP_COUNT_EN
    localparam bit ClipEn = 1'b1;
`else
    localparam bit ClipEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] peak_i, peak_q, clip_count;
    logic        peak_valid;

    axis_sc16_if s_if ();
    axis_sc16_if m_if ();

    axis_sc16_peak_meter #(
        .WIN_LOG2 (WinLog2),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .clear      (clear),
        .peak_i     (peak_i),
        .peak_q     (peak_q),
        .peak_valid (peak_valid),
        .clip_count (clip_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    int          win_i[$];
    int          win_q[$];
    int          exp_pi = 0;
    int          exp_pq = 0;
    int          exp_clip = 0;
    bit          exp_pv = 1'b0;
    bit          rdy_exp = 1'b0;
    bit          last_hs = 1'b0;

    function automatic int mag(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic bit is_clip(input logic [31:0] d);
        return (d[31:16] == 16'h7FFF) || (d[31:16] == 16'h8000) ||
               (d[15:0] == 16'h7FFF) || (d[15:0] == 16'h8000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("m_tvalid", 32'(m_if.tvalid), 32'(exp_d.size() != 0));
        chk("peak_valid", 32'(peak_valid), 32'(exp_pv));
        chk("peak_i", 32'(peak_i), exp_pi);
        chk("peak_q", 32'(peak_q), exp_pq);
        chk("clip_count", 32'(clip_count), ClipEn ? exp_clip : 0);
    endtask

    // One clock: drive after negedge, predict the edge, check at the following negedge
    task automatic cycle(input bit sv, input logic [31:0] d, input bit l, input bit mr,
                         input bit clr);
        s_if.tvalid = sv;
        s_if.tdata  = d;
        s_if.tlast  = l;
        m_if.tready = mr;
        clear       = clr;
        #1;
        chk("s_tready", 32'(s_if.tready), 32'(rdy_exp && (exp_d.size() == 0 || mr)));
        last_hs = s_if.tvalid && s_if.tready;
        if (m_if.tvalid && mr && exp_d.size() != 0) begin
            chk("m_tdata", m_if.tdata, exp_d[0]);
            chk("m_tlast", 32'(m_if.tlast), 32'(exp_l[0]));
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
        end
        if (last_hs) begin
            exp_d.push_back(d);
            exp_l.push_back(l);
        end
        exp_pv = 1'b0;
        if (clr) begin
            win_i.delete();
            win_q.delete();
            exp_clip = 0;
        end else if (last_hs) begin
            win_i.push_back(mag(d[31:16]));
            win_q.push_back(mag(d[15:0]));
            if (is_clip(d) && exp_clip < 65535) exp_clip++;
            if (win_i.size() == Win) begin
                exp_pi = 0;
                exp_pq = 0;
                foreach (win_i[k]) if (win_i[k] > exp_pi) exp_pi = win_i[k];
                foreach (win_q[k]) if (win_q[k] > exp_pq) exp_pq = win_q[k];
                exp_pv = 1'b1;
                win_i.delete();
                win_q.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int          sent;
        int          cyc;
        bit          pend;
        bit          sv;
        logic [31:0] cur;

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;

        // Reset: every output low, ready rises on the 2nd edge after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 32'(s_if.tready), 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_m_tlast", 32'(m_if.tlast), 0);
        check_outputs();
        rst_n       = 1'b1;
        m_if.tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_tready_edge1", 32'(s_if.tready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_tready_edge2", 32'(s_if.tready), 1);
        rdy_exp = 1'b1;

        // Window of zeros with one 0x0100_FF00, then a window of zeros
        for (int n = 0; n < Win; n++) cycle(1'b1, (n == 5) ? 32'h0100_FF00 : 32'h0, 1'b0, 1'b1,
                                            1'b0);
        chk("win1_strobe", 32'(peak_valid), 1);
        chk("win1_peak_i", 32'(peak_i), 256);
        chk("win1_peak_q", 32'(peak_q), 256);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("win1_strobe_once", 32'(peak_valid), 0);
        for (int n = 0; n < Win; n++) cycle(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("win2_peak_i", 32'(peak_i), 0);
        chk("win2_peak_q", 32'(peak_q), 0);

        // Full-scale item: magnitudes saturate, clip counted when enabled
        for (int n = 0; n < Win; n++) cycle(1'b1, (n == 3) ? 32'h8000_7FFF : 32'h0012_FFEE,
                                            1'b0, 1'b1, 1'b0);
        chk("fs_peak_i", 32'(peak_i), 32767);
        chk("fs_peak_q", 32'(peak_q), 32767);
        chk("fs_clip", 32'(clip_count), ClipEn ? 1 : 0);

        // Clear on the window-closing handshake suppresses the strobe
        for (int n = 0; n < Win; n++) cycle(1'b1, $urandom, 1'b0, 1'b1, (n == Win - 1));
        chk("clr_no_strobe", 32'(peak_valid), 0);
        for (int n = 0; n < Win - 1; n++) cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        chk("clr_15_no_strobe", 32'(peak_valid), 0);
        cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        chk("clr_16_strobe", 32'(peak_valid), 1);

        // Random stream with stalls on both sides, tlast every 64 items
        sent = 0;
        cyc  = 0;
        pend = 1'b0;
        cur  = $urandom;
        while ((sent < 256 || exp_d.size() != 0) && cyc < 4000) begin
            sv = pend || (sent < 256 && $urandom_range(0, 3) != 0);
            cycle(sv, cur, ((sent % 64) == 63), ($urandom_range(0, 3) != 0), 1'b0);
            if (last_hs) begin
                sent++;
                cur  = $urandom;
                pend = 1'b0;
            end else begin
                pend = sv;
            end
            cyc++;
        end
        chk("stream_sent", sent, 256);
        chk("stream_drained", exp_d.size(), 0);

        // Reset while an item is held by back-pressure
        for (int n = 0; n < 5; n++) cycle(1'b1, 32'h7000_9000 + n, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("held_valid", 32'(m_if.tvalid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", 32'(m_if.tvalid), 0);
        chk("mid_rst_tready", 32'(s_if.tready), 0);
        chk("mid_rst_peak_i", 32'(peak_i), 0);
        chk("mid_rst_peak_q", 32'(peak_q), 0);
        chk("mid_rst_clip", 32'(clip_count), 0);
        exp_d.delete();
        exp_l.delete();
        win_i.delete();
        win_q.delete();
        exp_pi   = 0;
        exp_pq   = 0;
        exp_clip = 0;
        exp_pv   = 1'b0;
        rdy_exp  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rdy_exp = 1'b1;
        for (int n = 0; n < Win - 1; n++) cycle(1'b1, 32'h0003_0004, 1'b0, 1'b1, 1'b0);
        chk("post_rst_15_no_strobe", 32'(peak_valid), 0);
        cycle(1'b1, 32'h0003_0004, 1'b0, 1'b1, 1'b0);
        chk("post_rst_strobe", 32'(peak_valid), 1);
        chk("post_rst_peak_i", 32'(peak_i), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
